// File: rtl/pla_prog_pipe.sv
// Run-time programmable two-level AND/OR array with a 2-cycle sample pipeline.
// Config writes are only taken while stage 1 is empty, so no sample sees a partial update.
module pla_prog_pipe #(
  parameter int NUM_IN    = 24,
  parameter int NUM_OUT   = 14,
  parameter int NUM_TERMS = 64,
  parameter int ADDR_W    = $clog2(NUM_TERMS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [NUM_IN-1:0]   x_in,
  output logic                out_valid,
  output logic [NUM_OUT-1:0]  z_out,
  output logic                cfg_ready,
  input  logic                cfg_we,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic                cfg_en,
  input  logic [NUM_IN-1:0]   cfg_mask,
  input  logic [NUM_IN-1:0]   cfg_val,
  input  logic [NUM_OUT-1:0]  cfg_or,
  input  logic                cfg_clr,
  input  logic                cfg_pol_we,
  input  logic [NUM_OUT-1:0]  cfg_pol
);

  logic [NUM_TERMS-1:0] term_en;
  logic [NUM_IN-1:0]    term_mask [NUM_TERMS];
  logic [NUM_IN-1:0]    term_val  [NUM_TERMS];
  logic [NUM_OUT-1:0]   term_or   [NUM_TERMS];
  logic [NUM_OUT-1:0]   pol;

  logic                 s1_v;
  logic [NUM_IN-1:0]    s1_x;
  logic [NUM_OUT-1:0]   sum;

  assign cfg_ready = ~s1_v;

  // Clear acts on every slot first; a same-cycle write to one slot then overrides its enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      pol     <= '0;
      term_en <= '0;
      for (int t = 0; t < NUM_TERMS; t++) begin
        term_mask[t] <= '0;
        term_val[t]  <= '0;
        term_or[t]   <= '0;
      end
    end else if (cfg_ready) begin
      if (cfg_pol_we) pol <= cfg_pol;
      for (int t = 0; t < NUM_TERMS; t++) begin
        if (cfg_we && (cfg_addr == ADDR_W'(t))) begin
          term_en[t]   <= cfg_en;
          term_mask[t] <= cfg_mask;
          term_val[t]  <= cfg_val;
          term_or[t]   <= cfg_or;
        end else if (cfg_clr) begin
          term_en[t] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s1_x <= '0;
    end else begin
      s1_v <= in_valid;
      s1_x <= x_in;
    end
  end

  always_comb begin
    sum = '0;
    for (int t = 0; t < NUM_TERMS; t++) begin
      if (term_en[t] && (&(~(s1_x ^ term_val[t]) | ~term_mask[t]))) begin
        sum = sum | term_or[t];
      end
    end
  end

  // z_out only updates for valid samples and otherwise holds its last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      z_out     <= '0;
    end else begin
      out_valid <= s1_v;
      if (s1_v) z_out <= pol ^ sum;
    end
  end

endmodule

// File: tb/tb_pla_prog_pipe.sv
// Directed self-checking bench for pla_prog_pipe; a 48-slot copy shares the inputs
// so out-of-range addressing can be observed next to the 64-slot instance.
module tb_pla_prog_pipe;

  localparam int NUM_IN  = 24;
  localparam int NUM_OUT = 14;
  localparam int ADDR_W  = 6;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic [NUM_IN-1:0]  x_in;
  logic               cfg_we;
  logic [ADDR_W-1:0]  cfg_addr;
  logic               cfg_en;
  logic [NUM_IN-1:0]  cfg_mask;
  logic [NUM_IN-1:0]  cfg_val;
  logic [NUM_OUT-1:0] cfg_or;
  logic               cfg_clr;
  logic               cfg_pol_we;
  logic [NUM_OUT-1:0] cfg_pol;

  logic               out_valid, out_valid48;
  logic [NUM_OUT-1:0] z_out, z_out48;
  logic               cfg_ready, cfg_ready48;

  int checks = 0;
  int fails  = 0;

  pla_prog_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x_in(x_in),
    .out_valid(out_valid), .z_out(z_out), .cfg_ready(cfg_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_en(cfg_en),
    .cfg_mask(cfg_mask), .cfg_val(cfg_val), .cfg_or(cfg_or),
    .cfg_clr(cfg_clr), .cfg_pol_we(cfg_pol_we), .cfg_pol(cfg_pol)
  );

  pla_prog_pipe #(.NUM_TERMS(48)) dut48 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x_in(x_in),
    .out_valid(out_valid48), .z_out(z_out48), .cfg_ready(cfg_ready48),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_en(cfg_en),
    .cfg_mask(cfg_mask), .cfg_val(cfg_val), .cfg_or(cfg_or),
    .cfg_clr(cfg_clr), .cfg_pol_we(cfg_pol_we), .cfg_pol(cfg_pol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] addr, input logic en, input logic [NUM_IN-1:0] mask,
                               input logic [NUM_IN-1:0] val, input logic [NUM_OUT-1:0] orb);
    cfg_we = 1'b1; cfg_addr = addr; cfg_en = en;
    cfg_mask = mask; cfg_val = val; cfg_or = orb;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic sendAndCheck(input string tag, input logic [NUM_IN-1:0] x,
                              input logic [NUM_OUT-1:0] exp_z, input logic [NUM_OUT-1:0] exp_z48);
    in_valid = 1'b1; x_in = x;
    tick();
    in_valid = 1'b0;
    tick();
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_z"}, 32'(z_out), 32'(exp_z));
    checkOutput({tag, "_z48"}, 32'(z_out48), 32'(exp_z48));
  endtask

  localparam logic [NUM_IN-1:0]  T0_MASK = 24'h00220F;
  localparam logic [NUM_IN-1:0]  T0_VAL  = 24'h002201;
  localparam logic [NUM_OUT-1:0] T0_OR   = 14'h0800;

  initial begin
    rst = 1'b1; in_valid = 1'b0; x_in = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_en = 1'b0; cfg_mask = '0; cfg_val = '0;
    cfg_or = '0; cfg_clr = 1'b0; cfg_pol_we = 1'b0; cfg_pol = '0;
    tick(); tick();
    rst = 1'b0;
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_z", 32'(z_out), 32'd0);
    checkOutput("rst_ready", 32'(cfg_ready), 32'd1);

    $display("[TB] basic term");
    applyStimulus(6'd0, 1'b1, T0_MASK, T0_VAL, T0_OR);
    sendAndCheck("t0_hit", 24'h002201, 14'h0800, 14'h0800);
    tick();
    checkOutput("hold_valid", 32'(out_valid), 32'd0);
    checkOutput("hold_z", 32'(z_out), 32'h0800);
    sendAndCheck("t0_miss", 24'h002203, 14'h0000, 14'h0000);

    $display("[TB] polarity");
    cfg_clr = 1'b1; cfg_pol_we = 1'b1; cfg_pol = 14'h3FFF;
    tick();
    cfg_clr = 1'b0; cfg_pol_we = 1'b0;
    sendAndCheck("pol_only", 24'h123456, 14'h3FFF, 14'h3FFF);
    applyStimulus(6'd0, 1'b1, T0_MASK, T0_VAL, T0_OR);
    sendAndCheck("pol_term", 24'h002201, 14'h37FF, 14'h37FF);
    cfg_pol_we = 1'b1; cfg_pol = 14'h0000;
    tick();
    cfg_pol_we = 1'b0;

    $display("[TB] same-cycle write and sample");
    cfg_we = 1'b1; cfg_addr = 6'd1; cfg_en = 1'b1; cfg_mask = '0; cfg_val = '0; cfg_or = 14'h0002;
    in_valid = 1'b1; x_in = 24'h002201;
    tick();
    cfg_we = 1'b0; in_valid = 1'b0;
    tick();
    checkOutput("same_cyc_valid", 32'(out_valid), 32'd1);
    checkOutput("same_cyc_z", 32'(z_out), 32'h0802);
    applyStimulus(6'd1, 1'b0, '0, '0, 14'h0002);
    sendAndCheck("mask0_en0", 24'h002201, 14'h0800, 14'h0800);

    $display("[TB] back-to-back");
    in_valid = 1'b1; x_in = 24'h002201;
    tick();
    checkOutput("b2b_ready1", 32'(cfg_ready), 32'd0);
    checkOutput("b2b_valid1", 32'(out_valid), 32'd0);
    x_in = 24'h002203;
    cfg_we = 1'b1; cfg_addr = 6'd2; cfg_en = 1'b1; cfg_mask = '0; cfg_val = '0; cfg_or = 14'h0004;
    tick();
    cfg_we = 1'b0;
    checkOutput("b2b_v0", 32'({out_valid, z_out}), 32'({1'b1, 14'h0800}));
    checkOutput("b2b_ready2", 32'(cfg_ready), 32'd0);
    x_in = 24'h102201;
    tick();
    checkOutput("b2b_v1", 32'({out_valid, z_out}), 32'({1'b1, 14'h0000}));
    x_in = 24'h000201;
    tick();
    checkOutput("b2b_v2", 32'({out_valid, z_out}), 32'({1'b1, 14'h0800}));
    x_in = 24'h002209;
    tick();
    checkOutput("b2b_v3", 32'({out_valid, z_out}), 32'({1'b1, 14'h0000}));
    checkOutput("b2b_ready5", 32'(cfg_ready), 32'd0);
    in_valid = 1'b0;
    tick();
    checkOutput("b2b_v4", 32'({out_valid, z_out}), 32'({1'b1, 14'h0000}));
    checkOutput("b2b_ready_end", 32'(cfg_ready), 32'd1);
    tick();
    checkOutput("b2b_idle", 32'(out_valid), 32'd0);
    sendAndCheck("blocked_write", 24'h002201, 14'h0800, 14'h0800);

    $display("[TB] clear plus write");
    cfg_clr = 1'b1;
    applyStimulus(6'd5, 1'b1, '0, '0, 14'h0001);
    cfg_clr = 1'b0;
    sendAndCheck("clr_wr_a", 24'h002201, 14'h0001, 14'h0001);
    sendAndCheck("clr_wr_b", 24'h000000, 14'h0001, 14'h0001);

    $display("[TB] address boundaries");
    applyStimulus(6'd63, 1'b1, '0, '0, 14'h2000);
    sendAndCheck("addr63", 24'h00ABCD, 14'h2001, 14'h0001);
    applyStimulus(6'd47, 1'b1, '0, '0, 14'h1000);
    sendAndCheck("addr47", 24'h00ABCD, 14'h3001, 14'h1001);

    $display("[TB] reset mid-stream");
    in_valid = 1'b1; x_in = 24'h002201;
    tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_z", 32'(z_out), 32'd0);
    checkOutput("mid_rst_ready", 32'(cfg_ready), 32'd1);
    tick();
    checkOutput("mid_rst_drop", 32'(out_valid), 32'd0);
    sendAndCheck("post_rst", 24'h002201, 14'h0000, 14'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pla_prog_pipe.md
Name: pla_prog_pipe

Overview:
- Run-time programmable two-level AND/OR logic array: a configurable successor to the fixed sum-of-products PLA blocks.
- Each product term holds a per-input care mask, a per-input value and a per-output OR connection.
- Per-output polarity register allows complemented (off-set) realisations.
- Sits between a config/CSR master and a data stream: samples on x_in, results on z_out after a fixed 2-cycle latency, with valid qualification.

Parameters:
- NUM_IN, 24, number of inputs (x bits)
- NUM_OUT, 14, number of outputs (z bits)
- NUM_TERMS, 64, number of product-term slots
- ADDR_W, $clog2(NUM_TERMS), width of the term address

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  sample present on x_in this cycle
- x_in  in  NUM_IN  input vector
- out_valid  out  1  z_out holds a new result this cycle
- z_out  out  NUM_OUT  result vector
- cfg_ready  out  1  configuration writes accepted this cycle
- cfg_we  in  1  write one term slot
- cfg_addr  in  ADDR_W  term slot index
- cfg_en  in  1  term enable
- cfg_mask  in  NUM_IN  1 = input participates in term
- cfg_val  in  NUM_IN  required level where the mask bit is 1
- cfg_or  in  NUM_OUT  1 = term drives that output
- cfg_clr  in  1  disable all terms
- cfg_pol_we  in  1  write the polarity register
- cfg_pol  in  NUM_OUT  1 = output inverted

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset:
  - out_valid=0, z_out=0.
  - All term enables=0; masks, values and OR bits=0.
  - Polarity=0.
  - Stage-1 register cleared and invalid.
  - cfg_ready=1 in the first cycle after reset.
- Pipeline:
  - Stage 1: on every cycle, register x_in and in_valid into s1_x/s1_v (no backpressure; a new sample may be accepted each cycle).
  - Stage 2: z_out <= pol ^ OR over enabled terms t with cfg_or[t] of (&(~(s1_x ^ val[t]) | ~mask[t])).
  - Stage 2 also registers out_valid <= s1_v.
  - Latency: in_valid at cycle n gives out_valid at n+2. z_out holds its last value while out_valid=0.
- Term semantics:
  - Term with mask=0 and en=1 always fires (constant 1).
  - en=0: term never fires, regardless of mask.
  - Term with cfg_or=0 has no effect.
  - Output with no firing term = pol bit.
- Configuration:
  - cfg_ready = ~s1_v (combinational from the register).
  - cfg_we, cfg_clr and cfg_pol_we are applied at the clock edge only when cfg_ready=1; otherwise ignored, not queued.
  - Write accepted at cycle t affects every sample with in_valid at cycle >= t, including a sample presented in the same cycle t. No sample ever sees a partially updated array.
  - cfg_addr >= NUM_TERMS: write ignored, no other slot changes.
  - cfg_clr clears all enables only; mask/val/or are retained.
  - cfg_clr and cfg_we in the same cycle: clear applied first, then the write. The addressed slot ends with en=cfg_en.
  - cfg_pol_we is independent of, and may coincide with, cfg_we/cfg_clr.
- Reset mid-stream: in-flight samples are dropped (no out_valid for them); configuration returns to the reset state.

Test Plan:
- Defaults. Term 0 = {en=1, mask on bits 13,9,3,2,1,0; val bits 13,9,0 = 1, others 0; or=bit 11}.
  - x_in=0x002201 -> two cycles later out_valid=1, z_out=0x0800.
  - Same vector with bit 1 set -> z_out=0x0000.
- Polarity: cfg_pol=0x3FFF with no terms enabled; x_in=any -> z_out=0x3FFF. Then enable term 0 as above with x_in=0x002201 -> z_out=0x37FF.
- Back-to-back: in_valid held for 5 cycles with distinct vectors -> 5 consecutive out_valid pulses in order.
  - cfg_ready=0 from the cycle after the first in_valid until the cycle after the last.
  - A cfg_we issued in that window is ignored (readback via outputs unchanged).
- Simultaneous: cfg_clr=1 and cfg_we to slot 5 (en=1, mask=0, or=0x0001) in one cycle -> every following sample gives z_out=0x0001. The slot-0 term is no longer active.
- Boundaries:
  - cfg_addr=NUM_TERMS-1 write works.
  - With NUM_TERMS=48 and ADDR_W=6, cfg_addr=63 is ignored.
  - Term with mask=0 and en=0 -> never fires.
- Reset: assert rst the cycle after in_valid -> out_valid stays 0, z_out=0, all terms disabled, cfg_ready=1 the next cycle.
